// File: rtl/seq_multiword_adder_pkg.sv
// Shared constants and FSM encoding for the sequential multiword adder.
// Imported by the adder top and by anything that inspects its state.
package seq_multiword_adder_pkg;

    localparam int ADDER_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/mix16bitaddr.sv
// 16-bit ripple-style adder with carry-in and carry-out.
// Purely combinational; the sequential wrapper feeds it one word per cycle.
module mix16bitaddr (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);

    assign {Cout, Sum} = 17'(A) + 17'(B) + 17'(Cin);

endmodule

// File: rtl/seq_multiword_adder.sv
// Sequential WORDS x 16-bit adder: one 16-bit word per cycle, LSW first,
// with the registered carry chained into the next word.
module seq_multiword_adder
    import seq_multiword_adder_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORDS*ADDER_W-1:0] a_in,
    input  logic [WORDS*ADDER_W-1:0] b_in,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDS*ADDER_W-1:0] sum_out,
    output logic                     cout_out
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int OFF_W = IDX_W + $clog2(ADDER_W);

    state_t state, state_n;

    logic [WORDS*ADDER_W-1:0] a_r;
    logic [WORDS*ADDER_W-1:0] b_r;
    logic [WORDS*ADDER_W-1:0] sum_r;
    logic                     carry_r;
    logic [IDX_W-1:0]         idx;

    logic [OFF_W-1:0]   off;
    logic [ADDER_W-1:0] add_a;
    logic [ADDER_W-1:0] add_b;
    logic [ADDER_W-1:0] add_sum;
    logic               add_cout;
    logic               last;
    logic               load;
    logic               step;

    // Word offset is idx*16, built by concatenation to keep widths exact.
    assign off   = {idx, 4'b0000};
    assign add_a = a_r[off +: ADDER_W];
    assign add_b = b_r[off +: ADDER_W];
    assign last  = (idx == IDX_W'(WORDS - 1));

    mix16bitaddr u_add (
        .A    (add_a),
        .B    (add_b),
        .Cin  (carry_r),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_n = ADD;
                end
            end
            ADD: begin
                step = 1'b1;
                if (last) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
        end else if (load) begin
            a_r     <= a_in;
            b_r     <= b_in;
            carry_r <= cin;
            idx     <= '0;
        end else if (step) begin
            sum_r[off +: ADDER_W] <= add_sum;
            carry_r               <= add_cout;
            if (!last) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Result stays on the outputs after release; valid only with out_valid.
    assign sum_out  = sum_r;
    assign cout_out = carry_r;

endmodule

// File: tb/tb_seq_multiword_adder.sv
// Directed-vector and random bench for seq_multiword_adder at WORDS=4 and WORDS=1.
module tb_seq_multiword_adder;

    typedef struct {
        string       nm;
        logic [63:0] a;
        logic [63:0] b;
        logic        c;
        logic [63:0] sum;
        logic        cout;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        iv = 1'b0;
    logic        ordy = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        c = 1'b0;
    bit          sel = 1'b0;

    logic        ir4, ov4, co4;
    logic [63:0] so4;
    logic        ir1, ov1, co1;
    logic [15:0] so1;

    logic        ir_s, ov_s, co_s;
    logic [63:0] so_s;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_multiword_adder #(.WORDS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv & ~sel),
        .in_ready  (ir4),
        .a_in      (a),
        .b_in      (b),
        .cin       (c),
        .out_valid (ov4),
        .out_ready (ordy & ~sel),
        .sum_out   (so4),
        .cout_out  (co4)
    );

    seq_multiword_adder #(.WORDS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv & sel),
        .in_ready  (ir1),
        .a_in      (a[15:0]),
        .b_in      (b[15:0]),
        .cin       (c),
        .out_valid (ov1),
        .out_ready (ordy & sel),
        .sum_out   (so1),
        .cout_out  (co1)
    );

    assign ir_s = sel ? ir1 : ir4;
    assign ov_s = sel ? ov1 : ov4;
    assign co_s = sel ? co1 : co4;
    assign so_s = sel ? {48'h0, so1} : so4;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [63:0] av, input logic [63:0] bv,
                        input logic cv, input string nm);
        @(negedge clk);
        chk({nm, " in_ready"}, 128'(ir_s), 128'(1));
        a  = av;
        b  = bv;
        c  = cv;
        iv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        a  = ~av;
        b  = ~bv;
        c  = ~cv;
    endtask

    task automatic wait_out(input int exp_lat, input string nm);
        int lat;
        lat = 1;
        while (!ov_s && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
    endtask

    task automatic release_out(input bit bp, input string nm);
        bit r;
        for (int g = 0; g < 50; g++) begin
            r    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            ordy = r;
            @(posedge clk);
            @(negedge clk);
            ordy = 1'b0;
            if (r) break;
        end
        chk({nm, " release out_valid"}, 128'(ov_s), 128'(0));
        chk({nm, " release in_ready"}, 128'(ir_s), 128'(1));
    endtask

    task automatic xact(input logic [63:0] av, input logic [63:0] bv,
                        input logic cv, input logic [63:0] es,
                        input logic ec, input bit bp, input string nm);
        send(av, bv, cv, nm);
        wait_out(sel ? 2 : 5, nm);
        chk({nm, " sum"}, 128'(so_s), 128'(es));
        chk({nm, " cout"}, 128'(co_s), 128'(ec));
        release_out(bp, nm);
    endtask

    vec_t vecs[6];

    initial begin
        logic [64:0] ref4;
        logic [16:0] ref1;
        logic [63:0] ra, rb, held;
        logic        rc;

        vecs[0] = '{"wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                    64'h0, 1'b1};
        vecs[1] = '{"wordwise", 64'h0001_0002_0003_0004,
                    64'h0010_0020_0030_0040, 1'b1,
                    64'h0011_0022_0033_0045, 1'b0};
        vecs[2] = '{"chain", 64'h0000_FFFF_0000_FFFF,
                    64'h0000_0001_0000_0001, 1'b0,
                    64'h0001_0000_0001_0000, 1'b0};
        vecs[3] = '{"allones", 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[4] = '{"msb", 64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
        vecs[5] = '{"cinonly", 64'h0, 64'h0, 1'b1, 64'h1, 1'b0};

        #12;
        chk("reset in_ready", 128'(ir4), 128'(1));
        chk("reset out_valid", 128'(ov4), 128'(0));
        chk("reset sum", 128'(so4), 128'(0));
        chk("reset cout", 128'(co4), 128'(0));
        chk("reset w1 in_ready", 128'(ir1), 128'(1));
        @(negedge clk);
        rst = 1'b0;

        sel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            xact(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sum,
                 vecs[i].cout, 1'b0, vecs[i].nm);
        end

        // Back-pressure in HOLD with a stray operand pulse.
        send(vecs[1].a, vecs[1].b, vecs[1].c, "bp");
        wait_out(5, "bp");
        for (int k = 0; k < 3; k++) begin
            ordy = 1'b0;
            iv   = 1'b1;
            a    = 64'h1234_5678_9ABC_DEF0;
            b    = 64'h1111_1111_1111_1111;
            chk("bp sum stable", 128'(so_s), 128'(vecs[1].sum));
            chk("bp in_ready", 128'(ir_s), 128'(0));
            chk("bp out_valid", 128'(ov_s), 128'(1));
            @(posedge clk);
            @(negedge clk);
        end
        iv   = 1'b0;
        ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy = 1'b0;
        chk("bp idle in_ready", 128'(ir_s), 128'(1));
        chk("bp idle out_valid", 128'(ov_s), 128'(0));
        chk("bp held sum", 128'(so_s), 128'(vecs[1].sum));
        chk("bp held cout", 128'(co_s), 128'(0));

        // Reset during the second ADD cycle.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "rst");
        @(posedge clk);
        @(negedge clk);
        chk("rst pre carry", 128'(co_s), 128'(1));
        rst = 1'b1;
        #1;
        chk("rst out_valid", 128'(ov_s), 128'(0));
        chk("rst sum", 128'(so_s), 128'(0));
        chk("rst cout", 128'(co_s), 128'(0));
        chk("rst in_ready", 128'(ir_s), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        xact(vecs[2].a, vecs[2].b, vecs[2].c, vecs[2].sum,
             vecs[2].cout, 1'b0, "post rst");

        // Random regression, WORDS=4 then WORDS=1.
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            for (int i = 0; i < 1000; i++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                rc = 1'($urandom_range(0, 1));
                if (i % 8 == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
                ref4 = 65'(ra) + 65'(rb) + 65'(rc);
                ref1 = 17'(ra[15:0]) + 17'(rb[15:0]) + 17'(rc);
                if (sel) begin
                    held = {48'h0, ref1[15:0]};
                    xact(ra, rb, rc, held, ref1[16], 1'b1, "rand w1");
                end else begin
                    xact(ra, rb, rc, ref4[63:0], ref4[64], 1'b1, "rand w4");
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
